// File: rtl/adc_spi_capture.sv
// Master-mode serial ADC capture: drives CS_n/SCLK from clk and shifts N_CH SDATA lanes in parallel.
// Define ADC_LEADZERO_CHECK_EN to add lead_err, which flags nonzero bits in the discarded frame MSBs.
module adc_spi_capture #(
  parameter int CLK_DIV    = 4,
  parameter int FRAME_BITS = 16,
  parameter int DATA_BITS  = 12,
  parameter int N_CH       = 2,
  parameter int QUIET_CLKS = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      continuous,
  input  logic [N_CH-1:0]           SDATA,
  output logic                      CS_n,
  output logic                      SCLK,
  output logic [N_CH*DATA_BITS-1:0] data_Out,
  output logic                      rx_done_tick,
  output logic                      busy
`ifdef ADC_LEADZERO_CHECK_EN
  ,
  output logic [N_CH-1:0]           lead_err
`endif
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(FRAME_BITS + 1);
  localparam int Q_W   = $clog2(QUIET_CLKS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [Q_W-1:0]   Q_LAST   = Q_W'(QUIET_CLKS - 1);

  typedef enum logic [1:0] {IDLE, CONVERT, QUIET} state_t;

  state_t                                state_q, state_d;
  logic [DIV_W-1:0]                      div_q, div_d;
  logic [BIT_W-1:0]                      bit_q, bit_d;
  logic [Q_W-1:0]                        quiet_q, quiet_d;
  logic                                  sclk_q, sclk_d;
  logic                                  cs_n_q, cs_n_d;
  logic                                  done_q, done_d;
  logic                                  busy_q, busy_d;
  logic [N_CH*DATA_BITS-1:0]             data_q, data_d;
  logic [N_CH-1:0][FRAME_BITS-1:0]       sh_q, sh_d;
`ifdef ADC_LEADZERO_CHECK_EN
  logic [N_CH-1:0]                       lead_q, lead_d;
`endif

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    quiet_d = quiet_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    done_d  = 1'b0;
    data_d  = data_q;
    sh_d    = sh_q;
`ifdef ADC_LEADZERO_CHECK_EN
    lead_d  = lead_q;
`endif
    case (state_q)
      IDLE: begin
        sclk_d = 1'b1;
        cs_n_d = 1'b1;
        if (start || continuous) begin
          state_d = CONVERT;
          cs_n_d  = 1'b0;
          div_d   = '0;
          bit_d   = '0;
        end
      end
      CONVERT: begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          // Capture on the rising SCLK edge; the final rise closes the frame in the same cycle.
          if (!sclk_q) begin
            for (int k = 0; k < N_CH; k++) begin
              sh_d[k] = {sh_q[k][FRAME_BITS-2:0], SDATA[k]};
            end
            bit_d = bit_q + 1'b1;
            if (bit_q == BIT_LAST) begin
              for (int k = 0; k < N_CH; k++) begin
                data_d[k*DATA_BITS +: DATA_BITS] = sh_d[k][DATA_BITS-1:0];
`ifdef ADC_LEADZERO_CHECK_EN
                lead_d[k] = |(sh_d[k] >> DATA_BITS);
`endif
              end
              done_d  = 1'b1;
              cs_n_d  = 1'b1;
              state_d = QUIET;
              quiet_d = '0;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      QUIET: begin
        sclk_d = 1'b1;
        cs_n_d = 1'b1;
        if (quiet_q == Q_LAST) begin
          state_d = IDLE;
          quiet_d = '0;
        end else begin
          quiet_d = quiet_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      quiet_q <= '0;
      sclk_q  <= 1'b1;
      cs_n_q  <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
`ifdef ADC_LEADZERO_CHECK_EN
      lead_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      quiet_q <= quiet_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
`ifdef ADC_LEADZERO_CHECK_EN
      lead_q  <= lead_d;
`endif
    end
  end

  // Shift registers are fully refilled every frame, so they carry no reset.
  always_ff @(posedge clk) begin
    sh_q <= sh_d;
  end

  assign CS_n         = cs_n_q;
  assign SCLK         = sclk_q;
  assign data_Out     = data_q;
  assign rx_done_tick = done_q;
  assign busy         = busy_q;
`ifdef ADC_LEADZERO_CHECK_EN
  assign lead_err     = lead_q;
`endif

endmodule

// File: tb/tb_adc_spi_capture.sv
// Bench for adc_spi_capture: default 2-lane instance plus a 1-lane CLK_DIV=2 / 14-bit instance,
// each fed by a behavioural MSB-first ADC that advances one bit per SCLK rise.
module tb_adc_spi_capture;
  localparam int FB = 16, DB = 12, NCH = 2, DIV = 4, QC = 8;
  localparam int FRAME_CYC = 2 * DIV * FB;
  localparam int PERIOD    = FRAME_CYC + QC + 1;
  localparam int FB5 = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset_n, start, continuous;
  logic [NCH-1:0]      sdata;
  logic                cs_n, sclk, done, busy;
  logic [NCH*DB-1:0]   dout;
  logic                start5, cont5, sdata5, cs5, sclk5, done5, busy5;
  logic [FB5-1:0]      dout5;
`ifdef ADC_LEADZERO_CHECK_EN
  logic [NCH-1:0]      lead_err;
  logic [0:0]          lead5;
`endif

  adc_spi_capture dut (
    .clk(clk), .reset_n(reset_n), .start(start), .continuous(continuous),
    .SDATA(sdata), .CS_n(cs_n), .SCLK(sclk), .data_Out(dout),
    .rx_done_tick(done), .busy(busy)
`ifdef ADC_LEADZERO_CHECK_EN
    , .lead_err(lead_err)
`endif
  );

  adc_spi_capture #(.CLK_DIV(2), .FRAME_BITS(FB5), .DATA_BITS(FB5), .N_CH(1), .QUIET_CLKS(8)) dut5 (
    .clk(clk), .reset_n(reset_n), .start(start5), .continuous(cont5),
    .SDATA(sdata5), .CS_n(cs5), .SCLK(sclk5), .data_Out(dout5),
    .rx_done_tick(done5), .busy(busy5)
`ifdef ADC_LEADZERO_CHECK_EN
    , .lead_err(lead5)
`endif
  );

  int errors = 0, checks = 0;
  int cyc = 0;
  int done_total = 0;
  always @(posedge clk) cyc++;
  always @(posedge clk) if (done) done_total++;

  // Behavioural ADCs: MSB presented when CS_n falls, next bit after each SCLK rise.
  logic [15:0] adc_word [NCH];
  logic [15:0] word5;
  int rise_total = 0, rise_base = 0, cs_fall_cyc = 0;
  int rise5_total = 0, rise5_base = 0, cs5_fall_cyc = 0;
  always @(posedge sclk) rise_total++;
  always @(negedge cs_n) begin rise_base = rise_total; cs_fall_cyc = cyc; end
  always @(posedge sclk5) rise5_total++;
  always @(negedge cs5) begin rise5_base = rise5_total; cs5_fall_cyc = cyc; end

  function automatic logic lane_bit(input logic [15:0] w, input int fb, input int n);
    int p;
    p = fb - 1 - n;
    if (p < 0) p = 0;
    if (p > 15) p = 15;
    return w[p];
  endfunction

  always_comb begin
    for (int k = 0; k < NCH; k++) sdata[k] = lane_bit(adc_word[k], FB, rise_total - rise_base);
    sdata5 = lane_bit(word5, FB5, rise5_total - rise5_base);
  end

  // Reference: the sample is the frame value modulo 2^DB; a lead error is a frame value >= 2^DB.
  function automatic logic [NCH*DB-1:0] exp_data(input logic [15:0] w0, input logic [15:0] w1);
    int lo0, lo1;
    lo0 = int'(w0) % (1 << DB);
    lo1 = int'(w1) % (1 << DB);
    return (NCH*DB)'(lo1 * (1 << DB) + lo0);
  endfunction

  function automatic logic [NCH-1:0] exp_lead(input logic [15:0] w0, input logic [15:0] w1);
    return {int'(w1) >= (1 << DB), int'(w0) >= (1 << DB)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_done(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s: no rx_done_tick within 400 cycles", name);
    end
  endtask

  task automatic wait_idle(input string name);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (!busy) begin idle = 1'b1; break; end
      @(negedge clk);
    end
    check({name, "_idle"}, 64'(idle), 64'(1));
  endtask

  typedef struct {
    logic [15:0]       w0;
    logic [15:0]       w1;
    logic [NCH*DB-1:0] exp;
    logic [NCH-1:0]    lead;
  } vec_t;

  task automatic do_frame(input string name, input vec_t v);
    bit ok;
    int d0;
    adc_word[0] = v.w0;
    adc_word[1] = v.w1;
    d0 = done_total;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check({name, "_busy"}, 64'(busy), 64'(1));
    wait_done(name, ok);
    if (ok) begin
      check({name, "_data"}, 64'(dout), 64'(v.exp));
      check({name, "_cslow"}, 64'(cyc - cs_fall_cyc), 64'(FRAME_CYC));
      check({name, "_rises"}, 64'(rise_total - rise_base), 64'(FB));
      check({name, "_csend"}, 64'({cs_n, sclk}), 64'(2'b11));
`ifdef ADC_LEADZERO_CHECK_EN
      check({name, "_lead"}, 64'(lead_err), 64'(v.lead));
`endif
      @(negedge clk);
      check({name, "_pulse"}, 64'(done), 64'(0));
    end
    wait_idle(name);
    check({name, "_count"}, 64'(done_total - d0), 64'(1));
  endtask

  vec_t tbl [10];
  logic [15:0] cw [3];
  int t_done [3];
  logic [13:0] w5 [2];

  initial begin
    bit ok, reached;
    int d0;

    tbl[0] = '{16'h0ABC, 16'h0123, 24'h123ABC, 2'b00};
    tbl[1] = '{16'hFFFF, 16'h0000, 24'h000FFF, 2'b01};
    tbl[2] = '{16'h0ABC, 16'h8ABC, 24'hABCABC, 2'b10};
    tbl[3] = '{16'h0ABC, 16'h0ABC, 24'hABCABC, 2'b00};
    for (int i = 4; i < 10; i++) begin
      tbl[i].w0   = 16'($urandom);
      tbl[i].w1   = 16'($urandom);
      tbl[i].exp  = exp_data(tbl[i].w0, tbl[i].w1);
      tbl[i].lead = exp_lead(tbl[i].w0, tbl[i].w1);
    end

    reset_n = 1'b1; start = 1'b0; continuous = 1'b0; start5 = 1'b0; cont5 = 1'b0;
    adc_word[0] = '0; adc_word[1] = '0; word5 = '0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_cs", 64'(cs_n), 64'(1));
    check("rst_sclk", 64'(sclk), 64'(1));
    check("rst_data", 64'(dout), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_cs", 64'(cs_n), 64'(1));

    // Table-driven single frames
    for (int i = 0; i < 10; i++) do_frame($sformatf("vec%0d", i), tbl[i]);

    // Continuous mode, dropped mid-way through the third frame
    cw[0] = 16'h0001; cw[1] = 16'h0FFF; cw[2] = 16'h0800;
    adc_word[0] = cw[0]; adc_word[1] = 16'h0456;
    d0 = done_total;
    @(negedge clk); continuous = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_done($sformatf("cont%0d", i), ok);
      t_done[i] = cyc;
      check($sformatf("cont%0d_data", i), 64'(dout), 64'(exp_data(cw[i], 16'h0456)));
      if (i < 2) adc_word[0] = cw[i+1];
      if (i == 1) begin
        repeat (40) @(negedge clk);
        continuous = 1'b0;
      end
    end
    check("cont_gap01", 64'(t_done[1] - t_done[0]), 64'(PERIOD));
    check("cont_gap12", 64'(t_done[2] - t_done[1]), 64'(PERIOD));
    repeat (300) @(negedge clk);
    check("cont_stop_count", 64'(done_total - d0), 64'(3));
    check("cont_stop_busy", 64'(busy), 64'(0));

    // Start pulses while busy are ignored
    adc_word[0] = 16'h0F0F; adc_word[1] = 16'h0321;
    d0 = done_total;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int j = 0; j < 6; j++) begin
      repeat (15) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done("busy_start", ok);
    check("busy_start_data", 64'(dout), 64'(exp_data(16'h0F0F, 16'h0321)));
    repeat (30) @(negedge clk);
    check("busy_start_count", 64'(done_total - d0), 64'(1));
    check("busy_start_idle", 64'(busy), 64'(0));

    // Asynchronous reset after the 7th SCLK rise, while SCLK is low
    adc_word[0] = 16'h0FED; adc_word[1] = 16'h0CBA;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if ((rise_total - rise_base) >= 7 && sclk == 1'b0) break;
      @(negedge clk);
    end
    reached = ((rise_total - rise_base) >= 7) && (sclk == 1'b0);
    check("arst_reached", 64'(reached), 64'(1));
    reset_n = 1'b0;
    #1;
    check("arst_cs", 64'(cs_n), 64'(1));
    check("arst_sclk", 64'(sclk), 64'(1));
    check("arst_data", 64'(dout), 64'(0));
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    do_frame("after_rst", tbl[0]);

    // Narrow instance: CLK_DIV=2, 14-bit frame kept whole
    w5[0] = 14'h2AAA;
    w5[1] = 14'($urandom);
    for (int i = 0; i < 2; i++) begin
      word5 = 16'(w5[i]);
      @(negedge clk); start5 = 1'b1;
      @(negedge clk); start5 = 1'b0;
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        if (done5) begin ok = 1'b1; break; end
      end
      check($sformatf("n14_%0d_seen", i), 64'(ok), 64'(1));
      if (ok) begin
        check($sformatf("n14_%0d_data", i), 64'(dout5), 64'(w5[i]));
        check($sformatf("n14_%0d_cslow", i), 64'(cyc - cs5_fall_cyc), 64'(2 * 2 * FB5));
        check($sformatf("n14_%0d_rises", i), 64'(rise5_total - rise5_base), 64'(FB5));
`ifdef ADC_LEADZERO_CHECK_EN
        check($sformatf("n14_%0d_lead", i), 64'(lead5), 64'(0));
`endif
      end
      repeat (15) @(negedge clk);
      check($sformatf("n14_%0d_idle", i), 64'(busy5), 64'(0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
